// File: rtl/arb_requester.sv
`default_nettype none
// ============================================================================
// Module      : arb_requester
// Description : Per-client pending-transaction counters feeding a round-robin
//               arbiter, with a two-state burst transfer engine.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_requester #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] push,
  input  logic [WIDTH-1:0] gnt,
  output logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] owner,
  output logic             beat,
  output logic             ack,
  output logic             err,
  output logic [WIDTH-1:0] ovf
);

  localparam int              c_beat_w  = $clog2(BURST + 1);
  localparam logic [c_beat_w-1:0] c_last    = c_beat_w'(BURST - 1);
  localparam logic [c_beat_w-1:0] c_beat_one = c_beat_w'(1);
  localparam logic [CNT_W-1:0]    c_cnt_max = '1;
  localparam logic [CNT_W-1:0]    c_cnt_one = CNT_W'(1);
  localparam logic [WIDTH-1:0]    c_gnt_one = WIDTH'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [WIDTH-1:0]            r_owner;
  logic [WIDTH-1:0]            w_owner_nxt;
  logic [c_beat_w-1:0]         r_beat;
  logic [c_beat_w-1:0]         w_beat_nxt;
  logic [WIDTH-1:0][CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]            r_ovf;
  logic                        w_done;
  logic                        w_legal;

  always_comb begin
    req = '0;
    for (int i = 0; i < WIDTH; i++) begin
      req[i] = (r_cnt[i] != '0) && !((r_state == S_XFER) && r_owner[i]);
    end
  end

  assign w_done  = (r_state == S_XFER) && (r_beat == c_last);
  assign w_legal = (gnt != '0) && ((gnt & (gnt - c_gnt_one)) == '0) &&
                   ((gnt & req) != '0);

  assign owner = r_owner;
  assign beat  = (r_state == S_XFER);
  assign ack   = w_done;
  assign ovf   = r_ovf;
  // Grants arriving while reset is held are ignored, so no error is reported.
  assign err   = rst && (r_state == S_IDLE) && (gnt != '0) && !w_legal;

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_beat_nxt  = r_beat;
    case (r_state)
      S_IDLE: begin
        if (w_legal) begin
          w_state_nxt = S_XFER;
          w_owner_nxt = gnt;
          w_beat_nxt  = '0;
        end
      end
      S_XFER: begin
        if (w_done) begin
          w_state_nxt = S_IDLE;
          w_owner_nxt = '0;
          w_beat_nxt  = '0;
        end else begin
          w_beat_nxt  = r_beat + c_beat_one;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_owner_nxt = '0;
        w_beat_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  // A push coinciding with its own client's completion cancels out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
      r_ovf <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (push[i] && !(w_done && r_owner[i])) begin
          if (r_cnt[i] == c_cnt_max) begin
            r_ovf[i] <= 1'b1;
          end else begin
            r_cnt[i] <= r_cnt[i] + c_cnt_one;
          end
        end else if (!push[i] && w_done && r_owner[i]) begin
          r_cnt[i] <= r_cnt[i] - c_cnt_one;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arb_requester.sv
`default_nettype none
// ============================================================================
// Module      : tb_arb_requester
// Description : Self-checking bench for arb_requester (table, directed, random).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_requester;

  localparam int W     = 4;
  localparam int CW    = 3;
  localparam int BURST = 4;
  localparam int MAXC  = (1 << CW) - 1;

  logic         clk;
  logic         rst;
  logic [W-1:0] push;
  logic [W-1:0] gnt;
  logic [W-1:0] req;
  logic [W-1:0] owner;
  logic         beat;
  logic         ack;
  logic         err;
  logic [W-1:0] ovf;

  arb_requester #(.WIDTH(W), .CNT_W(CW), .BURST(BURST)) dut (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .gnt   (gnt),
    .req   (req),
    .owner (owner),
    .beat  (beat),
    .ack   (ack),
    .err   (err),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ack_seen = 0;

  // Reference model: pending counts, current owner index (-1 idle), beats left
  int m_cnt [W];
  bit m_ovf [W];
  int m_own = -1;
  int m_left = 0;
  bit m_valid = 0;
  bit m_legal;
  logic [W-1:0] e_req, e_owner, e_ovf;
  logic         e_beat, e_ack, e_err;

  function automatic logic [W-1:0] model_req();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) r[i] = (m_cnt[i] > 0) && !(m_own == i);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_expect();
    bit busy;
    busy    = (m_own >= 0);
    e_beat  = busy;
    e_ack   = busy && (m_left == 1);
    e_owner = busy ? W'(1 << m_own) : '0;
    e_req   = model_req();
    m_legal = ($countones(gnt) == 1) && ((gnt & e_req) != '0);
    e_err   = rst && !busy && (gnt != '0) && !m_legal;
    for (int i = 0; i < W; i++) e_ovf[i] = m_ovf[i];
  endtask

  task automatic model_update();
    bit fin;
    if (!rst) begin
      for (int i = 0; i < W; i++) begin
        m_cnt[i] = 0;
        m_ovf[i] = 0;
      end
      m_own = -1; m_left = 0; m_valid = 1;
      return;
    end
    for (int i = 0; i < W; i++) begin
      fin = e_ack && (m_own == i);
      if (push[i] && !fin) begin
        if (m_cnt[i] == MAXC) m_ovf[i] = 1;
        else m_cnt[i]++;
      end else if (!push[i] && fin) begin
        m_cnt[i]--;
      end
    end
    if (m_own >= 0) begin
      if (e_ack) m_own = -1;
      else m_left--;
    end else if (m_legal) begin
      for (int i = 0; i < W; i++) if (gnt[i]) m_own = i;
      m_left = BURST;
    end
  endtask

  task automatic apply(input logic r, input logic [W-1:0] p, input logic [W-1:0] g);
    @(negedge clk);
    rst = r; push = p; gnt = g;
    #1;
    model_expect();
  endtask

  task automatic finish_cycle();
    if (m_valid) begin
      chk("req", req, e_req);
      chk("owner", owner, e_owner);
      chk("beat", beat, e_beat);
      chk("ack", ack, e_ack);
      chk("err", err, e_err);
      chk("ovf", ovf, e_ovf);
    end
    if (ack === 1'b1) ack_seen++;
    @(posedge clk);
    model_update();
  endtask

  task automatic step(input logic r, input logic [W-1:0] p, input logic [W-1:0] g);
    apply(r, p, g);
    finish_cycle();
  endtask

  task automatic do_reset();
    step(1'b0, '0, '0);
    step(1'b0, 4'b1111, 4'b0011);
  endtask

  typedef struct {
    logic         r;
    logic [W-1:0] p;
    logic [W-1:0] g;
    logic [W-1:0] req;
    logic [W-1:0] owner;
    logic         beat;
    logic         ack;
    logic         err;
  } vec_t;

  vec_t tbl [17];

  initial begin
    // Basic transfer, then illegal grants and a grant ignored during XFER
    tbl[0]  = '{1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 4'b0000, 4'b0010, 4'b0101, 4'b0000, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 4'b0000, 4'b0101, 4'b0101, 4'b0000, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 4'b0000, 4'b0000, 4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 4'b0000, 4'b0001, 4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 4'b0000, 4'b0001, 4'b0100, 4'b0001, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 4'b0000, 4'b0110, 4'b0100, 4'b0001, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 4'b0000, 4'b0000, 4'b0100, 4'b0001, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 4'b0000, 4'b0000, 4'b0100, 4'b0001, 1'b1, 1'b1, 1'b0};
    tbl[16] = '{1'b1, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0};

    rst = 1'b0; push = '0; gnt = '0;
    do_reset();

    for (int k = 0; k < 17; k++) begin
      apply(tbl[k].r, tbl[k].p, tbl[k].g);
      chk($sformatf("tbl%0d_req", k), req, tbl[k].req);
      chk($sformatf("tbl%0d_owner", k), owner, tbl[k].owner);
      chk($sformatf("tbl%0d_beat", k), beat, tbl[k].beat);
      chk($sformatf("tbl%0d_ack", k), ack, tbl[k].ack);
      chk($sformatf("tbl%0d_err", k), err, tbl[k].err);
      finish_cycle();
    end

    // Back-to-back: three transactions on client 2
    do_reset();
    for (int k = 0; k < 3; k++) step(1'b1, 4'b0100, '0);
    ack_seen = 0;
    for (int t = 0; t < 3; t++) begin
      step(1'b1, '0, 4'b0100);
      for (int b = 0; b < BURST; b++) step(1'b1, '0, '0);
    end
    apply(1'b1, '0, '0);
    chk("b2b_acks", ack_seen, 3);
    chk("b2b_req_after", req, 4'b0000);
    finish_cycle();

    // Overflow on client 1, sticky after draining
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b1, 4'b0010, '0);
    apply(1'b1, '0, '0);
    chk("ovf_set", ovf, 4'b0010);
    finish_cycle();
    for (int t = 0; t < MAXC; t++) begin
      step(1'b1, '0, 4'b0010);
      for (int b = 0; b < BURST; b++) step(1'b1, '0, '0);
    end
    apply(1'b1, '0, '0);
    chk("ovf_sticky", ovf, 4'b0010);
    chk("ovf_drained_req", req, 4'b0000);
    finish_cycle();

    // Push on client 3 during its own ack cycle
    do_reset();
    step(1'b1, 4'b1000, '0);
    step(1'b1, '0, 4'b1000);
    for (int b = 0; b < BURST - 1; b++) step(1'b1, '0, '0);
    apply(1'b1, 4'b1000, '0);
    chk("simul_ack", ack, 1'b1);
    finish_cycle();
    apply(1'b1, '0, '0);
    chk("simul_req3", req[3], 1'b1);
    finish_cycle();

    // Reset asserted on the second beat
    do_reset();
    step(1'b1, 4'b0001, '0);
    step(1'b1, '0, 4'b0001);
    step(1'b1, '0, '0);
    ack_seen = 0;
    step(1'b0, '0, '0);
    apply(1'b1, '0, '0);
    chk("rstmid_owner", owner, 4'b0000);
    chk("rstmid_beat", beat, 1'b0);
    chk("rstmid_req", req, 4'b0000);
    finish_cycle();
    for (int k = 0; k < 6; k++) step(1'b1, '0, '0);
    chk("rstmid_no_ack", ack_seen, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [W-1:0] rq, g, p;
      int sel, pick;
      logic r;
      rq  = model_req();
      sel = $urandom_range(0, 9);
      g   = '0;
      if (sel <= 5 && rq != '0) begin
        pick = $urandom_range(0, $countones(rq) - 1);
        for (int i = 0; i < W; i++) begin
          if (rq[i]) begin
            if (pick == 0) g[i] = 1'b1;
            pick--;
          end
        end
      end else if (sel >= 8) begin
        g = W'($urandom);
      end
      p = W'($urandom & $urandom);
      r = ($urandom_range(0, 149) != 0);
      step(r, p, g);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
